// File: rtl/spi_master_rw.sv
// SPI master (mode 0) for register access: one FRAME_W-bit frame per accepted command, read tail captured MSB-first.
// Latency: accept to csb rise CLK_DIV*(2*FRAME_W+1) clk, ready again CS_GAP later; commands offered while busy are dropped.
module spi_master_rw #(
    parameter int FRAME_W    = 24,
    parameter int RD_W       = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4,
    parameter int THREE_WIRE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic               busy,
    output logic               done,
    output logic [RD_W-1:0]    rd_data,
    output logic               rd_valid,
    output logic               sclk,
    output logic               csb,
    output logic               sdio_o,
    output logic               sdio_oe,
    input  logic               sdi
);
    localparam int BW = $clog2(FRAME_W);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
    localparam logic [BW-1:0] RD_LIM   = BW'(RD_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_H, SHIFT_L, HOLD, GAP} state_t;

    state_t             state, state_nx;
    logic [DW-1:0]      div_cnt, div_nx;
    logic [BW-1:0]      bit_cnt, bit_nx;
    logic [GW-1:0]      gap_cnt, gap_nx;
    logic [FRAME_W-1:0] tx_sh, tx_nx;
    logic [RD_W-1:0]    rx_sh, rx_nx, rx_shl;
    logic               is_rd, rd_nx;
    logic               sclk_nx, csb_nx, sdo_nx, oe_nx;
    logic               ready_nx, busy_nx, done_nx, rv_nx;
    logic [RD_W-1:0]    rdat_nx;
    logic               div_end;
    logic [BW-1:0]      bit_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            is_rd     <= 1'b0;
            sclk      <= 1'b0;
            csb       <= 1'b1;
            sdio_o    <= 1'b0;
            sdio_oe   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_nx;
            bit_cnt   <= bit_nx;
            gap_cnt   <= gap_nx;
            tx_sh     <= tx_nx;
            rx_sh     <= rx_nx;
            is_rd     <= rd_nx;
            sclk      <= sclk_nx;
            csb       <= csb_nx;
            sdio_o    <= sdo_nx;
            sdio_oe   <= oe_nx;
            cmd_ready <= ready_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            rd_valid  <= rv_nx;
            rd_data   <= rdat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        gap_nx   = gap_cnt;
        tx_nx    = tx_sh;
        rx_nx    = rx_sh;
        rd_nx    = is_rd;
        sclk_nx  = sclk;
        csb_nx   = csb;
        sdo_nx   = sdio_o;
        oe_nx    = sdio_oe;
        ready_nx = cmd_ready;
        busy_nx  = busy;
        done_nx  = 1'b0;
        rv_nx    = 1'b0;
        rdat_nx  = rd_data;
        div_end  = (div_cnt == DIV_LAST);
        bit_dec  = bit_cnt - 1'b1;
        rx_shl    = rx_sh << 1;
        rx_shl[0] = sdi;

        if (state == SETUP || state == SHIFT_H || state == SHIFT_L || state == HOLD)
            div_nx = div_end ? '0 : div_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nx = SETUP;
                    tx_nx    = cmd_data;
                    rd_nx    = cmd_data[FRAME_W-1];
                    rx_nx    = '0;
                    bit_nx   = BIT_LAST;
                    div_nx   = '0;
                    csb_nx   = 1'b0;
                    sdo_nx   = cmd_data[FRAME_W-1];
                    oe_nx    = 1'b1;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            SETUP: begin
                if (div_end) begin
                    sclk_nx  = 1'b1;
                    state_nx = SHIFT_H;
                end
            end
            SHIFT_H: begin
                if (div_end) begin
                    if (is_rd && bit_cnt < RD_LIM)
                        rx_nx = rx_shl;
                    sclk_nx = 1'b0;
                    if (bit_cnt != '0) begin
                        bit_nx   = bit_dec;
                        state_nx = SHIFT_L;
                        // Read tail: stop driving data; in 3-wire mode release the shared pad to the device.
                        if (is_rd && bit_dec < RD_LIM) begin
                            sdo_nx = 1'b0;
                            if (THREE_WIRE != 0)
                                oe_nx = 1'b0;
                        end else begin
                            sdo_nx = tx_sh[bit_dec];
                        end
                    end else begin
                        state_nx = HOLD;
                    end
                end
            end
            SHIFT_L: begin
                if (div_end) begin
                    sclk_nx  = 1'b1;
                    state_nx = SHIFT_H;
                end
            end
            HOLD: begin
                if (div_end) begin
                    csb_nx   = 1'b1;
                    oe_nx    = 1'b0;
                    sdo_nx   = 1'b0;
                    done_nx  = 1'b1;
                    gap_nx   = '0;
                    state_nx = GAP;
                    if (is_rd) begin
                        rv_nx   = 1'b1;
                        rdat_nx = rx_sh;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = '0;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_master_rw.sv
// Bench for spi_master_rw: default 3-wire instance plus a 16-bit 4-wire instance, directed and random frames
// checked against frame-level expectations (bit order, pad enable, latencies, read data).
module tb_spi_master_rw;
    localparam int AF = 24, AR = 8, AD = 2, AG = 4, AT = 1;
    localparam int BF = 16, BR = 8, BD = 1, BG = 2, BT = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        sel = 1'b0;
    logic        cv = 1'b0;
    logic [23:0] cd = '0;
    logic [7:0]  resp = '0;
    logic [7:0]  exp_rd_a = '0;
    logic [7:0]  exp_rd_b = '0;

    logic        a_cmd_valid, a_cmd_ready, a_busy, a_done, a_rd_valid, a_sclk, a_csb, a_sdio_o, a_sdio_oe;
    logic [23:0] a_cmd_data;
    logic [7:0]  a_rd_data;
    logic        a_sdi = 1'b0;
    logic        b_cmd_valid, b_cmd_ready, b_busy, b_done, b_rd_valid, b_sclk, b_csb, b_sdio_o, b_sdio_oe;
    logic [15:0] b_cmd_data;
    logic [7:0]  b_rd_data;
    logic        b_sdi = 1'b0;

    assign a_cmd_valid = cv && !sel;
    assign a_cmd_data  = cd;
    assign b_cmd_valid = cv && sel;
    assign b_cmd_data  = cd[15:0];

    spi_master_rw #(.FRAME_W(AF), .RD_W(AR), .CLK_DIV(AD), .CS_GAP(AG), .THREE_WIRE(AT)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_data(a_cmd_data), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .busy(a_busy), .done(a_done), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .sclk(a_sclk),
        .csb(a_csb), .sdio_o(a_sdio_o), .sdio_oe(a_sdio_oe), .sdi(a_sdi));

    spi_master_rw #(.FRAME_W(BF), .RD_W(BR), .CLK_DIV(BD), .CS_GAP(BG), .THREE_WIRE(BT)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_data(b_cmd_data), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .busy(b_busy), .done(b_done), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .sclk(b_sclk),
        .csb(b_csb), .sdio_o(b_sdio_o), .sdio_oe(b_sdio_oe), .sdi(b_sdi));

    logic       v_ready, v_busy, v_done, v_rd_valid, v_sclk, v_csb, v_sdio_o, v_sdio_oe;
    logic [7:0] v_rd_data;
    assign v_ready    = sel ? b_cmd_ready : a_cmd_ready;
    assign v_busy     = sel ? b_busy      : a_busy;
    assign v_done     = sel ? b_done      : a_done;
    assign v_rd_valid = sel ? b_rd_valid  : a_rd_valid;
    assign v_sclk     = sel ? b_sclk      : a_sclk;
    assign v_csb      = sel ? b_csb       : a_csb;
    assign v_sdio_o   = sel ? b_sdio_o    : a_sdio_o;
    assign v_sdio_oe  = sel ? b_sdio_oe   : a_sdio_oe;
    assign v_rd_data  = sel ? b_rd_data   : a_rd_data;

    // Device model: after each sclk fall it presents the next bit; read-tail bits come from resp, others are noise.
    function automatic logic slave_bit(input int idx, input int rw, input logic [7:0] r);
        if (idx >= 0 && idx < rw) return r[idx];
        return 1'($urandom);
    endfunction

    int   a_falls = 0;
    logic a_ps = 1'b0;
    always @(negedge clk) begin
        if (a_csb) a_falls = 0;
        else if (a_ps && !a_sclk) a_falls++;
        a_ps  = a_sclk;
        a_sdi = slave_bit(AF - 1 - a_falls, AR, resp);
    end

    int   b_falls = 0;
    logic b_ps = 1'b0;
    always @(negedge clk) begin
        if (b_csb) b_falls = 0;
        else if (b_ps && !b_sclk) b_falls++;
        b_ps  = b_sclk;
        b_sdi = slave_bit(BF - 1 - b_falls, BR, resp);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_idle(input bit s);
        sel = s;
        #1;
        chk("reset_csb", v_csb, 1);
        chk("reset_sclk", v_sclk, 0);
        chk("reset_sdio_o", v_sdio_o, 0);
        chk("reset_sdio_oe", v_sdio_oe, 0);
        chk("reset_ready", v_ready, 1);
        chk("reset_busy", v_busy, 0);
        chk("reset_done", v_done, 0);
        chk("reset_rd_valid", v_rd_valid, 0);
        chk("reset_rd_data", v_rd_data, 0);
    endtask

    task automatic run(input bit s, input logic [23:0] cmd, input logic [7:0] r,
                       input bit keep, input int poke_at, input int rst_at);
        int fw, rw, cdv, gap, lat_cs, lat_rdy;
        int cyc, rises, dones, rvs, rv_done, low, hi_busy, done_cyc, rise_cyc, viol;
        bit tw, rd, aborted;
        logic [23:0] obs_o, obs_oe, exp_o, exp_oe;
        logic prev_sclk, prev_o;
        logic [7:0] want_rd;
        fw  = s ? BF : AF;
        rw  = s ? BR : AR;
        cdv = s ? BD : AD;
        gap = s ? BG : AG;
        tw  = ((s ? BT : AT) != 0);
        lat_cs  = cdv * (2 * fw + 1);
        lat_rdy = lat_cs + gap;
        rd = cmd[fw-1];
        exp_o  = '0;
        exp_oe = '0;
        for (int n = fw - 1; n >= 0; n--) begin
            exp_o  = {exp_o[22:0], (rd && n < rw) ? 1'b0 : cmd[n]};
            exp_oe = {exp_oe[22:0], !(rd && n < rw && tw)};
        end

        sel  = s;
        resp = r;
        #1;
        cyc = 0;
        while (!v_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before_accept", v_ready, 1);
        cd = cmd;
        cv = 1'b1;
        @(negedge clk);
        if (!keep) cv = 1'b0;
        chk("ready_after_accept", v_ready, 0);
        chk("busy_after_accept", v_busy, 1);

        cyc = 0; rises = 0; dones = 0; rvs = 0; rv_done = 0; low = 0; hi_busy = 0; viol = 0;
        done_cyc = -1; rise_cyc = -1; aborted = 1'b0;
        obs_o = '0; obs_oe = '0; prev_sclk = 1'b0; prev_o = v_sdio_o;
        while (cyc <= lat_rdy + 20) begin
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_csb", v_csb, 1);
                chk("rst_sclk", v_sclk, 0);
                chk("rst_sdio_oe", v_sdio_oe, 0);
                chk("rst_ready", v_ready, 1);
                chk("rst_busy", v_busy, 0);
                chk("rst_rd_data", v_rd_data, 0);
                chk("rst_no_done", dones + 32'(v_done), 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                exp_rd_a = '0;
                exp_rd_b = '0;
                aborted = 1'b1;
                break;
            end
            if (cyc == poke_at) begin
                cd = ~cmd;
                cv = 1'b1;
            end
            if (poke_at > 0 && cyc == poke_at + 1) cv = 1'b0;
            if (!v_csb) low++;
            else if (rise_cyc < 0) rise_cyc = cyc;
            if (v_csb && v_busy) hi_busy++;
            if (v_sclk && !prev_sclk) begin
                rises++;
                obs_o  = {obs_o[22:0], v_sdio_o};
                obs_oe = {obs_oe[22:0], v_sdio_oe};
            end
            if (v_sclk && prev_sclk && v_sdio_o !== prev_o) viol++;
            if (v_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (v_rd_valid) begin
                rvs++;
                if (v_done) rv_done++;
            end
            prev_sclk = v_sclk;
            prev_o    = v_sdio_o;
            if (v_ready) break;
            @(negedge clk);
            cyc++;
        end

        if (!aborted) begin
            if (rd) begin
                if (s) exp_rd_b = r;
                else   exp_rd_a = r;
            end
            want_rd = s ? exp_rd_b : exp_rd_a;
            chk("ready_latency", cyc, lat_rdy);
            chk("csb_low_cycles", low, lat_cs);
            chk("csb_rise_cycle", rise_cyc, lat_cs);
            chk("done_cycle", done_cyc, lat_cs);
            chk("done_count", dones, 1);
            chk("rd_valid_count", rvs, rd);
            chk("rd_valid_with_done", rv_done, rd);
            chk("sclk_rises", rises, fw);
            chk("mosi_bits", obs_o, exp_o);
            chk("oe_at_rises", obs_oe, exp_oe);
            chk("csb_gap_cycles", hi_busy, gap);
            chk("sdio_stable_sclk_high", viol, 0);
            chk("rd_data", v_rd_data, want_rd);
            if (!keep) begin
                low = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (!v_csb) low++;
                end
                chk("no_extra_frame", low, 0);
            end
        end
    endtask

    initial begin
        logic [23:0] c;
        logic        s2;
        repeat (2) @(negedge clk);
        chk_idle(1'b0);
        chk_idle(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(1'b0, 24'h0012A5, 8'h00, 1'b0, -1, -1);
        run(1'b0, 24'h801200, 8'hC3, 1'b0, -1, -1);
        run(1'b0, 24'h005A3C, 8'h00, 1'b1, -1, -1);
        run(1'b0, 24'h803400, 8'h96, 1'b0, -1, -1);
        run(1'b0, 24'h0055AA, 8'h00, 1'b0, 40, -1);
        run(1'b0, 24'h00F00F, 8'h00, 1'b0, -1, 50);
        run(1'b0, 24'h001234, 8'h00, 1'b0, -1, -1);
        run(1'b1, 24'h008A00, 8'h5E, 1'b0, -1, -1);

        for (int i = 0; i < 10; i++) begin
            s2 = 1'($urandom);
            c  = 24'($urandom);
            run(s2, c, 8'($urandom), 1'b0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
